mcu_block_scheduler: RTL and testbench
======================================

# mcu_block_scheduler

- Sequences the three per-channel 8×8 block buffers (Y, Cb, Cr) onto the single shared downstream block path (DCT/quantiser input) in MCU order.
- Waits for the channel whose turn it is, captures its 512-bit block, and acknowledges the buffer so it can refill.
- Presents the block to the consumer with a valid/ready handshake and counts completed MCUs.
- Sits between the block buffers and the transform stage in the encoder datapath.

## Interface
Parameters:
- DATA_W, 512, flattened block width (64 × 8-bit pixels, pixel i at bits [i*8 +: 8]).
- MCU_CNT_W, 16, width of the completed-MCU counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  permits new grants; an in-flight transfer always completes.
- flush  in  1  synchronous abort; returns the scheduler to MCU slot 0.
- blk_valid  in  3  per-channel block available; bit0=Y, bit1=Cb, bit2=Cr (buffer block_valid).
- blk_data_y / blk_data_cb / blk_data_cr  in  DATA_W each  per-channel block data.
- blk_ack  out  3  one-cycle read-acknowledge pulse to the granted buffer.
- out_data  out  DATA_W  captured block.
- out_valid  out  1  out_data valid.
- out_channel  out  2  channel of out_data (0=Y, 1=Cb, 2=Cr).
- out_last  out  1  out_data is the last block of the MCU.
- out_ready  in  1  consumer accepts out_data.
- mcu_done  out  1  one-cycle pulse when the last block of an MCU is accepted.
- mcu_count  out  MCU_CNT_W  completed MCUs, wraps at 2^MCU_CNT_W.
- slot  out  3  current MCU slot index.

## Operation
- States:
  - WAIT: no block held.
  - SEND: a block is held on the output.
- WAIT:
  - The expected channel is SEQ[slot].
  - If enable=1 and blk_valid[expected]=1:
    - capture that channel's data into out_data;
    - set out_channel, and set out_last when slot is the final slot;
    - pulse blk_ack[expected];
    - set out_valid=1 and go to SEND.
  - blk_valid on a non-expected channel is ignored; that buffer holds its block until its turn.
- SEND:
  - out_data, out_channel, out_last and out_valid hold stable.
  - On out_ready=1:
    - clear out_valid and return to WAIT.
    - If the slot was final: slot←0, pulse mcu_done, increment mcu_count. Otherwise slot←slot+1.
- blk_ack is never asserted in SEND, and never to more than one channel in a cycle.
- out_ready while in WAIT has no effect.
- flush has the highest priority. It:
  - clears out_valid, out_last and blk_ack;
  - sets slot←0 and returns to WAIT;
  - preserves mcu_count;
  - discards the held block; that block was already acknowledged and is not re-requested.
- flush and out_ready in the same cycle: flush wins, with no mcu_done and no count.
- enable=0 in SEND: the handshake still completes.
- Reset (asynchronous, any state) clears everything to 0: state WAIT, slot, mcu_count, out_valid, out_last, out_channel, out_data, blk_ack, mcu_done.

## Timing
- Grant latency: blk_valid[expected] sampled high at edge N → blk_ack and out_valid high after edge N (registered, 1 cycle).
- blk_ack is high for exactly one cycle.
- A held block is accepted on the first edge with out_valid=out_ready=1.
- The next grant can occur at the earliest one cycle after acceptance (WAIT evaluated on the following edge). Peak throughput is 1 block per 2 cycles.
- mcu_done is registered: it is high in the cycle after the accepting edge. mcu_count updates on the same edge.

## Configuration
- SUBSAMPLE_420_EN defined:
  - SEQ = Y,Y,Y,Y,Cb,Cr (6 slots, final slot 5; 4:2:0).
- Not defined:
  - SEQ = Y,Cb,Cr (3 slots, final slot 2; 4:4:4).
  - slot never exceeds 2.

## Test plan
- 4:4:4, all blk_valid=1, out_ready=1 → grants Y,Cb,Cr.
  - One blk_ack per grant, each 1 cycle after its WAIT sample.
  - out_last only on Cr.
  - mcu_done once; mcu_count=1.
- 4:2:0, Cb and Cr valid from the start, Y valid for 4 blocks → sequence Y,Y,Y,Y,Cb,Cr.
  - No Cb/Cr ack before the fourth Y is accepted.
  - mcu_done after Cr.
- out_ready held low 10 cycles in SEND → out_data/out_channel stable, no further blk_ack; accepted on the cycle out_ready rises.
- enable=0 with blk_valid=3'b111 in WAIT → no ack, out_valid stays 0. enable=1 → grant of the expected channel after 1 cycle.
- flush asserted together with out_ready while holding Cb (4:4:4, slot 1) → out_valid=0, slot=0, no mcu_done, mcu_count unchanged; next grant is Y.
- rst_n pulsed low mid-SEND (asynchronous, between edges) → all outputs 0 immediately. mcu_count wrap: 2^MCU_CNT_W MCUs → mcu_count=0.

Source files
------------

// File: rtl/mcu_block_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mcu_block_scheduler
// Purpose  : Grants the Y/Cb/Cr block buffers in MCU order onto one shared
//            valid/ready block stream and counts completed MCUs.
//            SUBSAMPLE_420_EN selects 4:2:0 order (Y,Y,Y,Y,Cb,Cr); else 4:4:4.
// Revision : 1.0 - initial release
// ============================================================================
module mcu_block_scheduler #(
    parameter int DATA_W    = 512,
    parameter int MCU_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 flush,
    input  logic [2:0]           blk_valid,
    input  logic [DATA_W-1:0]    blk_data_y,
    input  logic [DATA_W-1:0]    blk_data_cb,
    input  logic [DATA_W-1:0]    blk_data_cr,
    output logic [2:0]           blk_ack,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_valid,
    output logic [1:0]           out_channel,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 mcu_done,
    output logic [MCU_CNT_W-1:0] mcu_count,
    output logic [2:0]           slot
);

    typedef enum logic [0:0] {
        ST_WAIT = 1'b0,
        ST_SEND = 1'b1
    } state_t;

`ifdef SUBSAMPLE_420_EN
    localparam logic [2:0] C_FINAL_SLOT = 3'd5;
`else
    localparam logic [2:0] C_FINAL_SLOT = 3'd2;
`endif

    state_t                 r_state, w_state_nxt;
    logic [2:0]             r_slot, w_slot_nxt;
    logic [MCU_CNT_W-1:0]   r_mcu_count, w_mcu_count_nxt;
    logic                   r_out_valid, w_out_valid_nxt;
    logic                   r_out_last, w_out_last_nxt;
    logic [1:0]             r_out_channel, w_out_channel_nxt;
    logic [DATA_W-1:0]      r_out_data, w_out_data_nxt;
    logic [2:0]             r_blk_ack, w_blk_ack_nxt;
    logic                   r_mcu_done, w_mcu_done_nxt;

    logic [1:0]             w_exp_ch;
    logic                   w_exp_valid;
    logic [DATA_W-1:0]      w_exp_data;
    logic [2:0]             w_exp_ack;

    // Channel whose turn it is, and that channel's buffer signals
    always_comb begin
        w_exp_ch = 2'd0;
`ifdef SUBSAMPLE_420_EN
        case (r_slot)
            3'd4:    w_exp_ch = 2'd1;
            3'd5:    w_exp_ch = 2'd2;
            default: w_exp_ch = 2'd0;
        endcase
`else
        case (r_slot)
            3'd1:    w_exp_ch = 2'd1;
            3'd2:    w_exp_ch = 2'd2;
            default: w_exp_ch = 2'd0;
        endcase
`endif
    end

    always_comb begin
        w_exp_valid = blk_valid[0];
        w_exp_data  = blk_data_y;
        w_exp_ack   = 3'b001;
        case (w_exp_ch)
            2'd1: begin
                w_exp_valid = blk_valid[1];
                w_exp_data  = blk_data_cb;
                w_exp_ack   = 3'b010;
            end
            2'd2: begin
                w_exp_valid = blk_valid[2];
                w_exp_data  = blk_data_cr;
                w_exp_ack   = 3'b100;
            end
            default: ;
        endcase
    end

    // Next-state and registered-output logic; flush overrides everything
    always_comb begin
        w_state_nxt       = r_state;
        w_slot_nxt        = r_slot;
        w_mcu_count_nxt   = r_mcu_count;
        w_out_valid_nxt   = r_out_valid;
        w_out_last_nxt    = r_out_last;
        w_out_channel_nxt = r_out_channel;
        w_out_data_nxt    = r_out_data;
        w_blk_ack_nxt     = 3'b000;
        w_mcu_done_nxt    = 1'b0;

        if (flush) begin
            w_state_nxt     = ST_WAIT;
            w_slot_nxt      = 3'd0;
            w_out_valid_nxt = 1'b0;
            w_out_last_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (enable && w_exp_valid) begin
                        w_out_data_nxt    = w_exp_data;
                        w_out_channel_nxt = w_exp_ch;
                        w_out_last_nxt    = (r_slot == C_FINAL_SLOT);
                        w_blk_ack_nxt     = w_exp_ack;
                        w_out_valid_nxt   = 1'b1;
                        w_state_nxt       = ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (out_ready) begin
                        w_out_valid_nxt = 1'b0;
                        w_state_nxt     = ST_WAIT;
                        if (r_slot == C_FINAL_SLOT) begin
                            w_slot_nxt      = 3'd0;
                            w_mcu_done_nxt  = 1'b1;
                            w_mcu_count_nxt = r_mcu_count + MCU_CNT_W'(1);
                        end else begin
                            w_slot_nxt = r_slot + 3'd1;
                        end
                    end
                end
                default: w_state_nxt = ST_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_WAIT;
            r_slot        <= 3'd0;
            r_mcu_count   <= '0;
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_out_channel <= 2'd0;
            r_out_data    <= '0;
            r_blk_ack     <= 3'b000;
            r_mcu_done    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_slot        <= w_slot_nxt;
            r_mcu_count   <= w_mcu_count_nxt;
            r_out_valid   <= w_out_valid_nxt;
            r_out_last    <= w_out_last_nxt;
            r_out_channel <= w_out_channel_nxt;
            r_out_data    <= w_out_data_nxt;
            r_blk_ack     <= w_blk_ack_nxt;
            r_mcu_done    <= w_mcu_done_nxt;
        end
    end

    assign blk_ack     = r_blk_ack;
    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign out_channel = r_out_channel;
    assign out_last    = r_out_last;
    assign mcu_done    = r_mcu_done;
    assign mcu_count   = r_mcu_count;
    assign slot        = r_slot;

endmodule
`default_nettype wire

// File: tb/tb_mcu_block_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcu_block_scheduler
// Purpose  : Random buffer/consumer traffic against a block-stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcu_block_scheduler;

    localparam int DW = 512;
    localparam int CW = 4;

`ifdef SUBSAMPLE_420_EN
    localparam int NSLOT = 6;
    int seq [NSLOT] = '{0, 0, 0, 0, 1, 2};
`else
    localparam int NSLOT = 3;
    int seq [NSLOT] = '{0, 1, 2};
`endif

    logic           clk;
    logic           rst_n;
    logic           enable;
    logic           flush;
    logic [2:0]     blk_valid;
    logic [DW-1:0]  blk_data_y, blk_data_cb, blk_data_cr;
    logic [2:0]     blk_ack;
    logic [DW-1:0]  out_data;
    logic           out_valid;
    logic [1:0]     out_channel;
    logic           out_last;
    logic           out_ready;
    logic           mcu_done;
    logic [CW-1:0]  mcu_count;
    logic [2:0]     slot;

    mcu_block_scheduler #(.DATA_W(DW), .MCU_CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
        .blk_valid(blk_valid), .blk_data_y(blk_data_y),
        .blk_data_cb(blk_data_cb), .blk_data_cr(blk_data_cr),
        .blk_ack(blk_ack), .out_data(out_data), .out_valid(out_valid),
        .out_channel(out_channel), .out_last(out_last), .out_ready(out_ready),
        .mcu_done(mcu_done), .mcu_count(mcu_count), .slot(slot)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    // Blocks each buffer has offered, oldest first
    logic [DW-1:0] q_y [$];
    logic [DW-1:0] q_cb [$];
    logic [DW-1:0] q_cr [$];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int qsize(input int c);
        if (c == 0) return q_y.size();
        if (c == 1) return q_cb.size();
        return q_cr.size();
    endfunction

    task automatic qpop(input int c, output logic [DW-1:0] d);
        if (c == 0)      d = q_y.pop_front();
        else if (c == 1) d = q_cb.pop_front();
        else             d = q_cr.pop_front();
    endtask

    // ---------------- stimulus: buffers and consumer ----------------
    int         mode;       // 0 stream, 1 random, 2 consumer stalled
    logic [2:0] vld;

    task automatic cycle();
        logic [DW-1:0] d;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            if (blk_ack[c]) vld[c] = 1'b0;
            if (!vld[c] && (mode != 1 || $urandom_range(1, 0) == 0)) begin
                for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
                if (c == 0)      begin blk_data_y  = d; q_y.push_back(d);  end
                else if (c == 1) begin blk_data_cb = d; q_cb.push_back(d); end
                else             begin blk_data_cr = d; q_cr.push_back(d); end
                vld[c] = 1'b1;
            end
        end
        blk_valid = vld;
        case (mode)
            0: begin enable = 1'b1; out_ready = 1'b1; flush = 1'b0; end
            1: begin
                enable    = ($urandom_range(3, 0) != 0);
                out_ready = ($urandom_range(2, 0) != 0);
                flush     = ($urandom_range(19, 0) == 0);
            end
            default: begin enable = 1'b1; out_ready = 1'b0; flush = 1'b0; end
        endcase
    endtask

    // ---------------- monitor / scoreboard ----------------
    int            m_slot;
    logic [CW-1:0] m_count;
    logic          m_held;
    logic [DW-1:0] h_data;
    logic [1:0]    h_ch;
    logic          h_last;
    logic [2:0]    exp_ack;
    logic [1:0]    exp_ch;
    logic          exp_done;

    initial begin
        m_slot = 0; m_count = '0; m_held = 1'b0; h_data = '0; h_ch = 2'd0;
        h_last = 1'b0; exp_ack = 3'b000; exp_ch = 2'd0; exp_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset out_valid", out_valid, 1'b0);
                chk("reset blk_ack", blk_ack, 3'b000);
                chk("reset mcu_count", mcu_count, '0);
                chk("reset slot", slot, 3'd0);
                chk("reset mcu_done", mcu_done, 1'b0);
                m_slot = 0; m_count = '0; m_held = 1'b0;
                exp_ack = 3'b000; exp_done = 1'b0;
            end else begin
                chk("blk_ack", blk_ack, exp_ack);
                if (exp_ack != 3'b000) begin
                    if (qsize(int'(exp_ch)) == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL grant: channel %0d granted with no block offered", exp_ch);
                    end else begin
                        qpop(int'(exp_ch), h_data);
                    end
                    h_ch   = exp_ch;
                    h_last = (m_slot == NSLOT - 1);
                    m_held = 1'b1;
                end
                chk("out_valid", out_valid, m_held);
                if (m_held) begin
                    chk("out_data", out_data, h_data);
                    chk("out_channel", out_channel, h_ch);
                    chk("out_last", out_last, h_last);
                end
                chk("mcu_done", mcu_done, exp_done);
                chk("mcu_count", mcu_count, m_count);
                chk("slot", slot, m_slot);

                // what the coming edge must do
                exp_ack  = 3'b000;
                exp_done = 1'b0;
                if (flush) begin
                    m_held = 1'b0;
                    m_slot = 0;
                end else if (m_held) begin
                    if (out_ready) begin
                        m_held = 1'b0;
                        if (m_slot == NSLOT - 1) begin
                            m_slot   = 0;
                            m_count  = m_count + 1'b1;
                            exp_done = 1'b1;
                        end else begin
                            m_slot = m_slot + 1;
                        end
                    end
                end else if (enable && blk_valid[seq[m_slot]]) begin
                    exp_ch  = 2'(seq[m_slot]);
                    exp_ack = 3'b001 << seq[m_slot];
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        bit found;
        rst_n = 1'b0; enable = 1'b0; flush = 1'b0; out_ready = 1'b0;
        blk_valid = 3'b000; vld = 3'b000; mode = 0;
        blk_data_y = '0; blk_data_cb = '0; blk_data_cr = '0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        mode = 0; repeat (300) cycle();
        mode = 1; repeat (2000) cycle();
        mode = 2; repeat (15) cycle();
        mode = 0; repeat (40) cycle();

        // asynchronous reset while a block is held
        mode  = 2;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            cycle();
            found = out_valid && (blk_ack == 3'b000);
        end
        if (!found) begin
            n_vec++; n_err++;
            $display("FAIL reset-setup: no held block within 50 cycles");
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async out_valid", out_valid, 1'b0);
        chk("async out_data", out_data, '0);
        chk("async out_channel", out_channel, 2'd0);
        chk("async out_last", out_last, 1'b0);
        chk("async blk_ack", blk_ack, 3'b000);
        chk("async mcu_done", mcu_done, 1'b0);
        chk("async mcu_count", mcu_count, '0);
        chk("async slot", slot, 3'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        mode = 1; repeat (1500) cycle();
        mode = 0; repeat (200) cycle();
        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
